sqrt_scheduler: RTL and testbench

- Time-shared integer square-root engine serving N_REQ independent requesters.
- Round-robin arbiter accepts one radicand at a time and drives a sequential digit-by-digit isqrt core.
- Returns floor root, remainder and requester ID on a single valid/ready response channel.
- Synthesizable replacement for the behavioural real-valued sqrt in the math datapath; all arithmetic is unsigned integer.

---
 rtl/sqrt_pkg.sv | 29 ++
 rtl/isqrt_core.sv | 82 ++++++++
 rtl/sqrt_scheduler_checker.sv | 53 +++++
 rtl/sqrt_scheduler.sv | 132 +++++++++++++
 tb/tb_sqrt_scheduler.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and constants for the time-shared integer square-root engine.
package sqrt_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Floor square root by greedy bit setting; used by scoreboards.
  function automatic logic [31:0] ref_isqrt(input logic [63:0] x);
    logic [63:0] r;
    logic [63:0] t;
    r = 64'd0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r[31:0];
  endfunction

endpackage

// File: rtl/isqrt_core.sv
// Digit-by-digit integer square root: one root bit per cycle, MSB first.
module isqrt_core
  import sqrt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   radicand,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem
);

  localparam int H  = WIDTH / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;

  logic [WIDTH-1:0] x_r, x_src_s;
  logic [H-1:0]     root_r, root_src_s, root_nxt_s;
  logic [H:0]       rem_r, rem_src_s, rem_nxt_s, diff_s;
  logic [H+2:0]     rem_t_s, trial_s;
  logic             ge_s;
  logic [CW-1:0]    cnt_r;
  logic             busy_r, done_r;

  // Iteration datapath; the start cycle already performs the first step.
  always_comb begin
    if (start) begin
      x_src_s    = radicand;
      root_src_s = '0;
      rem_src_s  = '0;
    end else begin
      x_src_s    = x_r;
      root_src_s = root_r;
      rem_src_s  = rem_r;
    end
    rem_t_s    = {rem_src_s, x_src_s[WIDTH-1 -: 2]};
    trial_s    = {1'b0, root_src_s, 2'b01};
    ge_s       = (rem_t_s >= trial_s);
    diff_s     = rem_t_s[H:0] - trial_s[H:0];
    rem_nxt_s  = ge_s ? diff_s : rem_t_s[H:0];
    root_nxt_s = {root_src_s[H-2:0], ge_s};
  end

  // Shift/subtract state and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r    <= '0;
      root_r <= '0;
      rem_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start) begin
        x_r    <= {x_src_s[WIDTH-3:0], 2'b00};
        root_r <= root_nxt_s;
        rem_r  <= rem_nxt_s;
        cnt_r  <= CW'(H - 1);
        busy_r <= 1'b1;
      end else if (busy_r) begin
        x_r    <= {x_src_s[WIDTH-3:0], 2'b00};
        root_r <= root_nxt_s;
        rem_r  <= rem_nxt_s;
        cnt_r  <= cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign root = root_r;
  assign rem  = rem_r;

endmodule

// File: rtl/sqrt_scheduler_checker.sv
// Invariant monitor for sqrt_scheduler: one-hot accept and root/remainder identity.
module sqrt_scheduler_checker
  import sqrt_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic [N_REQ-1:0]       req_valid,
  input logic [N_REQ-1:0]       req_ready,
  input logic [N_REQ*WIDTH-1:0] req_data,
  input logic                   resp_valid,
  input logic [WIDTH/2-1:0]     resp_root,
  input logic [WIDTH/2:0]       resp_rem
);

  logic [WIDTH-1:0] sel_s, x_cap_r;
  logic [WIDTH+1:0] recon_s;
  logic             hit_s;

  // Radicand of whichever requester handshakes this cycle.
  always_comb begin
    sel_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sel_s = sel_s | (req_data[k*WIDTH +: WIDTH] & {WIDTH{req_valid[k] & req_ready[k]}});
    end
    hit_s = |(req_valid & req_ready);
  end

  assign recon_s = (WIDTH+2)'(resp_root) * (WIDTH+2)'(resp_root) + (WIDTH+2)'(resp_rem);

  // Remember the radicand in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cap_r <= '0;
    end else if (hit_s) begin
      x_cap_r <= sel_s;
    end
  end

  // Invariants sampled on every active edge out of reset.
  always @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(req_ready));
      if (resp_valid) begin
        assert (recon_s == (WIDTH+2)'(x_cap_r));
        assert ((WIDTH/2+2)'(resp_rem) <= {1'b0, resp_root, 1'b0});
      end
    end
  end

endmodule

// File: rtl/sqrt_scheduler.sv
// Round-robin front end sharing one isqrt_core among N_REQ requesters,
// with a single registered valid/ready response channel.
module sqrt_scheduler
  import sqrt_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*WIDTH-1:0]      req_data,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [WIDTH/2-1:0]          resp_root,
  output logic [WIDTH/2:0]            resp_rem,
  output logic [id_width(N_REQ)-1:0]  resp_id
);

  localparam int IDW = id_width(N_REQ);
  localparam int PW  = IDW + 1;

  state_e           state_r, state_nxt_s;
  logic [IDW-1:0]   rr_ptr_r, grant_s, next_ptr_s, id_r, resp_id_r;
  logic [IDW:0]     idx_s, inc_s;
  logic             found_s, hit_s, start_s;
  logic [WIDTH-1:0] radicand_s;
  logic             core_busy_s, core_done_s;
  logic [WIDTH/2-1:0] core_root_s, resp_root_r;
  logic [WIDTH/2:0]   core_rem_s, resp_rem_r;
  logic             resp_valid_r;

  // Round-robin search starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found_s = 1'b0;
    grant_s = '0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s   = {1'b0, rr_ptr_r} + PW'(k);
      idx_s   = (idx_s >= PW'(N_REQ)) ? (idx_s - PW'(N_REQ)) : idx_s;
      hit_s   = !found_s && req_valid[idx_s[IDW-1:0]];
      grant_s = hit_s ? idx_s[IDW-1:0] : grant_s;
      found_s = found_s | hit_s;
    end
    inc_s      = {1'b0, grant_s} + PW'(1);
    next_ptr_s = (inc_s >= PW'(N_REQ)) ? '0 : inc_s[IDW-1:0];
  end

  assign radicand_s = req_data[int'(grant_s)*WIDTH +: WIDTH];

  // FSM next-state and request accept.
  always_comb begin
    state_nxt_s = state_r;
    req_ready   = '0;
    start_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          req_ready[grant_s] = 1'b1;
          start_s            = 1'b1;
          state_nxt_s        = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        // A core that stops without reporting done returns us to IDLE.
        if (core_done_s) begin
          state_nxt_s = DONE;
        end else if (core_busy_s) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, arbitration pointer and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      rr_ptr_r     <= '0;
      id_r         <= '0;
      resp_valid_r <= 1'b0;
      resp_root_r  <= '0;
      resp_rem_r   <= '0;
      resp_id_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (start_s) begin
        rr_ptr_r <= next_ptr_s;
        id_r     <= grant_s;
      end
      if (core_done_s) begin
        resp_valid_r <= 1'b1;
        resp_root_r  <= core_root_s;
        resp_rem_r   <= core_rem_s;
        resp_id_r    <= id_r;
      end else if (resp_valid_r && resp_ready) begin
        resp_valid_r <= 1'b0;
      end
    end
  end

  isqrt_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_s),
    .radicand (radicand_s),
    .busy     (core_busy_s),
    .done     (core_done_s),
    .root     (core_root_s),
    .rem      (core_rem_s)
  );

  assign resp_valid = resp_valid_r;
  assign resp_root  = resp_root_r;
  assign resp_rem   = resp_rem_r;
  assign resp_id    = resp_id_r;

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Directed and randomized self-checking bench for sqrt_scheduler (N_REQ=4, WIDTH=32).
module tb_sqrt_scheduler;
  import sqrt_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam int H = W / 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_data;
  logic           resp_valid, resp_ready;
  logic [H-1:0]   resp_root;
  logic [H:0]     resp_rem;
  logic [1:0]     resp_id;

  int n_checks = 0;
  int n_pass   = 0;
  int mh       = 0;

  always #5 clk = ~clk;

  sqrt_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_root(resp_root), .resp_rem(resp_rem), .resp_id(resp_id)
  );

  sqrt_scheduler_checker #(.N_REQ(N), .WIDTH(W)) u_chk (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .resp_valid(resp_valid), .resp_root(resp_root), .resp_rem(resp_rem)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [31:0] x);
    req_data[id*W +: W] = x;
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_resp(input string tag);
    int c;
    c = 0;
    while (!resp_valid && c < 60) begin
      if (!$onehot0(req_ready)) mh++;
      step();
      c++;
    end
    check_eq({tag, " valid"}, resp_valid, 1);
  endtask

  // Single request from an idle scheduler, with latency measurement.
  task automatic do_req(input int id, input logic [31:0] x, input int er, input int erem, input string tag);
    int wc, lat;
    set_req(id, x);
    #1;
    wc = 0;
    while (!req_ready[id] && wc < 50) begin
      step();
      wc++;
    end
    check_eq({tag, " grant"}, req_ready[id], 1);
    step();
    req_valid[id] = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 60) begin
      step();
      lat++;
    end
    check_eq({tag, " latency"}, lat, H + 1);
    check_eq({tag, " root"}, resp_root, er);
    check_eq({tag, " rem"}, resp_rem, erem);
    check_eq({tag, " id"}, resp_id, id);
    step();
  endtask

  int          exp_id4[6]   = '{0, 1, 2, 3, 0, 1};
  int          root4[4]     = '{10, 14, 17, 20};
  int          rem4[4]      = '{0, 4, 11, 0};
  logic [31:0] x4[4]        = '{32'd100, 32'd200, 32'd300, 32'd400};
  logic [33:0] exp_q[$];

  initial begin
    int spur, done_n, cyc;
    logic [N-1:0] acc;
    logic [33:0] e;
    logic [63:0] r, xv;

    rst_n = 1'b0; req_valid = '0; req_data = '0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst req_ready", req_ready, 0);
    check_eq("rst resp_valid", resp_valid, 0);
    check_eq("rst resp_root", resp_root, 0);
    check_eq("rst resp_rem", resp_rem, 0);
    check_eq("rst resp_id", resp_id, 0);
    rst_n = 1'b1;
    step();

    do_req(0, 32'd144, 12, 0, "x144");
    do_req(0, 32'd150, 12, 6, "x150");
    do_req(0, 32'd0, 0, 0, "x0");
    do_req(1, 32'd1, 1, 0, "x1");
    do_req(2, 32'hFFFF_FFFF, 65535, 131070, "xmax");
    do_req(3, 32'h4000_0000, 32768, 0, "x2p30");

    // All four requesters held valid across reset release.
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, x4[i]);
    step();
    rst_n = 1'b1;
    for (int s = 0; s < 6; s++) begin
      wait_resp("rr");
      check_eq("rr id", resp_id, exp_id4[s]);
      check_eq("rr root", resp_root, root4[exp_id4[s]]);
      check_eq("rr rem", resp_rem, rem4[exp_id4[s]]);
      if (s == 5) req_valid = '0;
      step();
    end

    // Only 1 and 3 pending with pointer at 2.
    set_req(1, 32'd49);
    set_req(3, 32'd50);
    #1;
    wait_resp("pair a");
    check_eq("pair a id", resp_id, 3);
    check_eq("pair a root", resp_root, 7);
    check_eq("pair a rem", resp_rem, 1);
    req_valid[3] = 1'b0;
    step();
    wait_resp("pair b");
    check_eq("pair b id", resp_id, 1);
    check_eq("pair b root", resp_root, 7);
    check_eq("pair b rem", resp_rem, 0);
    req_valid[1] = 1'b0;
    step();
    check_eq("pair onehot", mh, 0);

    // Backpressure in DONE.
    resp_ready = 1'b0;
    set_req(0, 32'd1000000);
    #1;
    check_eq("bp grant", req_ready[0], 1);
    step();
    req_valid[0] = 1'b0;
    wait_resp("bp");
    set_req(2, 32'd2);
    #1;
    for (int c = 0; c < 5; c++) begin
      check_eq("bp hold valid", resp_valid, 1);
      check_eq("bp hold root", resp_root, 1000);
      check_eq("bp hold rem", resp_rem, 0);
      check_eq("bp hold id", resp_id, 0);
      check_eq("bp no accept", req_ready, 0);
      step();
    end
    resp_ready = 1'b1;
    step();
    check_eq("bp release valid", resp_valid, 0);
    check_eq("bp release grant", req_ready, 4'b0100);
    step();
    req_valid[2] = 1'b0;
    wait_resp("bp next");
    check_eq("bp next id", resp_id, 2);
    check_eq("bp next root", resp_root, 1);
    check_eq("bp next rem", resp_rem, 1);
    step();

    // Reset in the middle of a computation.
    set_req(1, 32'd12345);
    #1;
    step();
    req_valid[1] = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check_eq("mid rst valid", resp_valid, 0);
    check_eq("mid rst ready", req_ready, 0);
    check_eq("mid rst root", resp_root, 0);
    check_eq("mid rst rem", resp_rem, 0);
    check_eq("mid rst id", resp_id, 0);
    step();
    step();
    rst_n = 1'b1;
    spur = 0;
    for (int c = 0; c < 25; c++) begin
      if (resp_valid) spur++;
      step();
    end
    check_eq("mid rst no resp", spur, 0);
    set_req(0, 32'd81);
    set_req(3, 32'd16);
    #1;
    check_eq("post rst grant", req_ready, 4'b0001);
    step();
    req_valid[0] = 1'b0;
    wait_resp("post rst a");
    check_eq("post rst a id", resp_id, 0);
    check_eq("post rst a root", resp_root, 9);
    check_eq("post rst a rem", resp_rem, 0);
    step();
    wait_resp("post rst b");
    check_eq("post rst b id", resp_id, 3);
    check_eq("post rst b root", resp_root, 4);
    check_eq("post rst b rem", resp_rem, 0);
    req_valid[3] = 1'b0;
    step();

    // Random traffic with stalls, scoreboarded against ref_isqrt.
    mh = 0; done_n = 0; cyc = 0;
    while (done_n < 400 && cyc < 30000) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000)));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (!$onehot0(req_ready)) mh++;
      acc = req_valid & req_ready;
      for (int i = 0; i < N; i++)
        if (acc[i]) exp_q.push_back({2'(i), req_data[i*W +: W]});
      if (resp_valid && resp_ready) begin
        check_eq("rand queue", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e  = exp_q.pop_front();
          xv = {32'd0, e[31:0]};
          r  = {32'd0, ref_isqrt(xv)};
          check_eq("rand id", resp_id, e[33:32]);
          check_eq("rand root", resp_root, r);
          check_eq("rand rem", resp_rem, xv - r * r);
        end
        done_n++;
      end
      step();
      cyc++;
      req_valid = req_valid & ~acc;
    end
    check_eq("rand count", done_n, 400);
    check_eq("rand onehot", mh, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
